// File: rtl/mac_seq_multiplier_if.sv
// Handshake and data bus between the MAC controller (master) and the
// sequential multiplier (slave).
interface mac_seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned PW = 2 * WIDTH;

  logic          clr_n;
  logic          load_mult;
  logic          begin_mult;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic          end_mult;
  logic          busy;
  logic          err;
  logic [PW-1:0] product;

  modport master (
    output clr_n, load_mult, begin_mult, a_in, b_in,
    input  end_mult, busy, err, product
  );

  modport slave (
    input  clr_n, load_mult, begin_mult, a_in, b_in,
    output end_mult, busy, err, product
  );
endinterface

// File: rtl/mac_seq_multiplier.sv
// Shift-add multiplier, one partial product per clock, WIDTH cycles per multiply.
// Define MAC_SIGNED_MULT_EN for two's-complement operands and signed product.
module mac_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_seq_multiplier_if.slave   bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, LOADED, BUSY, DONE} state_t;

  state_t           r_state, w_nx_state;
  logic [WIDTH-1:0] r_a, w_nx_a;
  logic [WIDTH-1:0] r_b, w_nx_b;
  logic [PW-1:0]    r_p, w_nx_p;
  logic [CW-1:0]    r_cnt, w_nx_cnt;
  logic             r_end, w_nx_end;
  logic             r_err, w_nx_err;
  logic             r_busy;
  logic             w_last;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // One iteration of the partial-product accumulation, WIDTH+1 bits wide
  always_comb begin
    w_addend = '0;
    w_sum    = '0;
`ifdef MAC_SIGNED_MULT_EN
    if (r_p[0]) w_addend = {r_a[WIDTH-1], r_a};
    if (w_last) w_sum = {r_p[PW-1], r_p[PW-1:WIDTH]} - w_addend;
    else        w_sum = {r_p[PW-1], r_p[PW-1:WIDTH]} + w_addend;
`else
    if (r_p[0]) w_addend = {1'b0, r_a};
    w_sum = {1'b0, r_p[PW-1:WIDTH]} + w_addend;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_a     <= w_nx_a;
      r_b     <= w_nx_b;
      r_p     <= w_nx_p;
      r_cnt   <= w_nx_cnt;
      r_end   <= w_nx_end;
      r_err   <= w_nx_err;
      r_busy  <= (w_nx_state == BUSY);
    end
  end

  // Load wins over begin; a begin that cannot be honoured flags err
  always_comb begin
    w_nx_state = r_state;
    w_nx_a     = r_a;
    w_nx_b     = r_b;
    w_nx_p     = r_p;
    w_nx_cnt   = r_cnt;
    w_nx_end   = r_end;
    w_nx_err   = 1'b0;

    if (!bus.clr_n) begin
      w_nx_state = IDLE;
      w_nx_a     = '0;
      w_nx_b     = '0;
      w_nx_p     = '0;
      w_nx_cnt   = '0;
      w_nx_end   = 1'b0;
    end else begin
      case (r_state)
        IDLE, LOADED, DONE: begin
          if (bus.load_mult) begin
            w_nx_a     = bus.a_in;
            w_nx_b     = bus.b_in;
            w_nx_p     = '0;
            w_nx_end   = 1'b0;
            w_nx_state = LOADED;
            w_nx_err   = bus.begin_mult;
          end else if (bus.begin_mult) begin
            if (r_state == IDLE) begin
              w_nx_err = 1'b1;
            end else begin
              w_nx_p     = {{WIDTH{1'b0}}, r_b};
              w_nx_cnt   = '0;
              w_nx_end   = 1'b0;
              w_nx_state = BUSY;
            end
          end
        end
        BUSY: begin
          w_nx_p   = {w_sum, r_p[WIDTH-1:1]};
          w_nx_cnt = r_cnt + CW'(1);
          w_nx_err = bus.load_mult | bus.begin_mult;
          if (w_last) begin
            w_nx_state = DONE;
            w_nx_end   = 1'b1;
          end
        end
        default: w_nx_state = IDLE;
      endcase
    end
  end

  assign bus.end_mult = r_end;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.product  = r_p;

endmodule

// File: doc/mac_seq_multiplier.md
Name: mac_seq_multiplier

Overview:
- Sequential shift-add multiplier for the MAC datapath.
- Responder side of the MAC controller handshake: it consumes load_mult, begin_mult and the controller's active-low clear, and returns end_mult plus the 2*WIDTH-bit product for the accumulator's add step.
- Computes one partial product per clock; WIDTH cycles per multiply.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_n  in  1  synchronous clear, active-low; driven by the controller's reset_out.
- load_mult  in  1  capture a_in/b_in this edge.
- begin_mult  in  1  start a multiply on the captured operands.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- end_mult  out  1  result valid; held until consumed.
- busy  out  1  multiply in progress.
- err  out  1  one-cycle pulse on a protocol violation.
- product  out  2*WIDTH  result; valid only while end_mult=1.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - a_reg, b_reg, P (product register), cnt are all 0.
  - end_mult=0, busy=0, err=0, product=0.
  - Reset mid-multiply aborts with no residue.
- clr_n=0 at a clock edge: same effect as reset, applied synchronously. It has highest priority over load_mult and begin_mult.
- All outputs are registered. busy=1 exactly when state=BUSY. product is P.
- State machine; load_mult has priority over begin_mult:
  - IDLE:
    - load_mult -> a_reg<=a_in, b_reg<=b_in, P<=0; go to LOADED.
    - begin_mult alone -> err pulse; stay in IDLE.
  - LOADED:
    - load_mult -> recapture operands; stay in LOADED.
    - begin_mult -> P<={WIDTH'b0, b_reg}, cnt<=0; go to BUSY.
  - BUSY (one iteration per edge):
    - sum[WIDTH:0] = P[2W-1:W] + (P[0] ? a_reg : 0), computed WIDTH+1 bits wide.
    - P <= {sum, P[WIDTH-1:1]}; cnt<=cnt+1.
    - On the iteration where cnt=WIDTH-1: go to DONE and set end_mult<=1 on the same edge.
    - load_mult or begin_mult in BUSY -> ignored, err pulse; the operation continues unaffected.
  - DONE:
    - end_mult=1 and P are held indefinitely.
    - load_mult -> capture new operands, end_mult<=0, P<=0; go to LOADED.
    - begin_mult -> restart on the same a_reg/b_reg, end_mult<=0; go to BUSY.
- Latency: begin_mult sampled at edge k -> end_mult=1 after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- Simultaneous load_mult and begin_mult outside BUSY: the load is performed, the begin is dropped, err pulses.
- err is high for exactly one cycle per offending edge. A clear or reset forces err to 0.
- Arithmetic is unsigned modulo nothing: the full 2*WIDTH-bit product is exact.
  - Example: 255*255=0xFE01 at WIDTH=8.

Optional Feature:
- Macro: MAC_SIGNED_MULT_EN.
- Defined: a_in/b_in are two's complement and product is the signed 2*WIDTH-bit result.
  - sum is formed from sign-extended P[2W-1:W] and sign-extended a_reg.
  - On the final iteration (cnt=WIDTH-1), if P[0]=1 the partial product is subtracted instead of added.
  - The shift is arithmetic: the new top bit is sum[WIDTH].
- Undefined: unsigned behaviour exactly as above. Ports, latency and handshake are identical in both builds.

Test Plan (WIDTH=8):
- load a=13, b=11, then begin next cycle -> busy high for 8 cycles; end_mult=1 exactly 8 cycles after the begin edge; product=143; end_mult held until the next load.
- Back-to-back operands: a=255, b=255 -> 0xFE01. Then load a=0, b=200, begin -> end_mult drops the cycle after the load; product=0.
- Protocol errors:
  - begin_mult in IDLE right after reset -> err one cycle, state stays IDLE.
  - begin_mult during BUSY cycle 4 -> err one cycle; result still 143 at the original time.
- clr_n low for 1 cycle during BUSY cycle 3 -> next edge: busy=0, end_mult=0, product=0; a following begin_mult -> err (IDLE).
- In DONE, begin_mult without load -> recompute and yield 143 again after 8 cycles. Then load (a=2, b=3) and begin on the same edge -> err pulse, state LOADED; a separate begin -> product=6.
- MAC_SIGNED_MULT_EN defined:
  - a=0xFD (-3), b=5 -> product=0xFFF1.
  - a=0x80, b=0x80 -> product=0x4000.
  - a=0x7F, b=0x80 -> product=0xC080.
